mem_bus_ctrl: RTL and testbench

MEM-stage data-memory access unit that consumes the EX/MEM pipeline register outputs and forwards results to the MEM/WB register. For load/store aluops it runs a registered req/ack transaction on the data bus and holds the pipeline via stallreq until the transaction completes. For all other aluops the writeback fields pass straight through. It is the responding end of the memory-op fields (aluop, mem_addr, reg2) launched by the EX/MEM register.

---
 rtl/mem_bus_ctrl_pkg.sv | 61 ++++++
 rtl/mem_bus_ctrl_if.sv | 17 +
 rtl/mem_lane_fmt.sv | 62 ++++++
 rtl/mem_bus_ctrl.sv | 154 +++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_ctrl_pkg.sv
// Shared types, aluop codes and lane-select constants for the MEM-stage data-memory unit.
package mem_bus_ctrl_pkg;

  localparam int unsigned ALU_OP_W   = 8;
  localparam int unsigned REG_W      = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned LANE_W     = 4;

  typedef logic [ALU_OP_W-1:0]   alu_op_t;
  typedef logic [REG_W-1:0]      reg_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [LANE_W-1:0]     sel_t;

  localparam alu_op_t EXE_OR_OP  = 8'b0010_0101;
  localparam alu_op_t EXE_LB_OP  = 8'b1110_0000;
  localparam alu_op_t EXE_LBU_OP = 8'b1110_0100;
  localparam alu_op_t EXE_LH_OP  = 8'b1110_0001;
  localparam alu_op_t EXE_LHU_OP = 8'b1110_0101;
  localparam alu_op_t EXE_LW_OP  = 8'b1110_0011;
  localparam alu_op_t EXE_SB_OP  = 8'b1110_1000;
  localparam alu_op_t EXE_SH_OP  = 8'b1110_1001;
  localparam alu_op_t EXE_SW_OP  = 8'b1110_1011;

  // Big-endian lanes: byte offset 0 lives in bits 31:24
  localparam sel_t SEL_NONE = 4'b0000;
  localparam sel_t SEL_B0   = 4'b1000;
  localparam sel_t SEL_B1   = 4'b0100;
  localparam sel_t SEL_B2   = 4'b0010;
  localparam sel_t SEL_B3   = 4'b0001;
  localparam sel_t SEL_H0   = 4'b1100;
  localparam sel_t SEL_H1   = 4'b0011;
  localparam sel_t SEL_WORD = 4'b1111;

  typedef enum logic [1:0] {ACC_NONE, ACC_BYTE, ACC_HALF, ACC_WORD} acc_size_t;
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

  typedef struct packed {
    logic we;
    reg_t addr;
    sel_t sel;
    reg_t wdata;
  } bus_cmd_t;

  function automatic acc_size_t acc_size(input alu_op_t op);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: acc_size = ACC_BYTE;
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: acc_size = ACC_HALF;
      EXE_LW_OP, EXE_SW_OP:             acc_size = ACC_WORD;
      default:                          acc_size = ACC_NONE;
    endcase
  endfunction

  function automatic logic is_store(input alu_op_t op);
    is_store = (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
  endfunction

  function automatic logic is_signed_load(input alu_op_t op);
    is_signed_load = (op == EXE_LB_OP) || (op == EXE_LH_OP);
  endfunction

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// Data-bus req/ack interface between the MEM-stage controller and memory.
interface mem_bus_ctrl_if;
  import mem_bus_ctrl_pkg::*;

  logic bus_req;
  logic bus_we;
  reg_t bus_addr;
  sel_t bus_sel;
  reg_t bus_wdata;
  reg_t bus_rdata;
  logic bus_ack;

  modport master (output bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
                  input  bus_rdata, bus_ack);
  modport slave  (input  bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
                  output bus_rdata, bus_ack);
endinterface

// File: rtl/mem_lane_fmt.sv
// Byte-lane formatting: lane select, store replication, load extraction/extension, alignment.
module mem_lane_fmt
  import mem_bus_ctrl_pkg::*;
(
  input  alu_op_t    aluop,
  input  logic [1:0] addr_lo,
  input  reg_t       store_data,
  input  reg_t       rdata,
  output sel_t       sel_c,
  output reg_t       wdata_c,
  output reg_t       load_data_c,
  output logic       misaligned_c
);

  acc_size_t   size;
  logic        sext;
  logic [7:0]  lb;
  logic [15:0] lh;

  always_comb begin
    size         = acc_size(aluop);
    sext         = is_signed_load(aluop);
    sel_c        = SEL_NONE;
    wdata_c      = '0;
    load_data_c  = '0;
    misaligned_c = 1'b0;
    lh           = addr_lo[1] ? rdata[15:0] : rdata[31:16];
    case (addr_lo)
      2'd0:    lb = rdata[31:24];
      2'd1:    lb = rdata[23:16];
      2'd2:    lb = rdata[15:8];
      default: lb = rdata[7:0];
    endcase

    case (size)
      ACC_BYTE: begin
        case (addr_lo)
          2'd0:    sel_c = SEL_B0;
          2'd1:    sel_c = SEL_B1;
          2'd2:    sel_c = SEL_B2;
          default: sel_c = SEL_B3;
        endcase
        wdata_c     = {4{store_data[7:0]}};
        load_data_c = {{24{sext & lb[7]}}, lb};
      end
      ACC_HALF: begin
        misaligned_c = addr_lo[0];
        sel_c        = addr_lo[1] ? SEL_H1 : SEL_H0;
        wdata_c      = {2{store_data[15:0]}};
        load_data_c  = {{16{sext & lh[15]}}, lh};
      end
      ACC_WORD: begin
        misaligned_c = |addr_lo;
        sel_c        = SEL_WORD;
        wdata_c      = store_data;
        load_data_c  = rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// MEM-stage data-memory access unit: req/ack bus transaction for loads/stores, passthrough otherwise.
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [5:0] stall,
  input  reg_addr_t  wd_i,
  input  logic       wreg_i,
  input  reg_t       wdata_i,
  input  reg_t       hi_i,
  input  reg_t       lo_i,
  input  logic       whilo_i,
  input  alu_op_t    aluop_i,
  input  reg_t       mem_addr_i,
  input  reg_t       reg2_i,
  mem_bus_ctrl_if.master bus,
  output reg_addr_t  wd_o,
  output logic       wreg_o,
  output reg_t       wdata_o,
  output reg_t       hi_o,
  output reg_t       lo_o,
  output logic       whilo_o,
  output logic       stallreq,
  output logic       align_err,
  output logic       bus_err
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 32'd0);

  state_t           state_q, state_d;
  bus_cmd_t         cmd_q;
  logic             req_q;
  reg_t             rdata_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;

  sel_t sel_c;
  reg_t st_data_c;
  reg_t ld_data_c;
  logic misaligned_c;
  logic is_mem;
  logic go;
  logic timeout_hit;
  logic unused_stall;

  mem_lane_fmt u_lane_fmt (
    .aluop        (aluop_i),
    .addr_lo      (mem_addr_i[1:0]),
    .store_data   (reg2_i),
    .rdata        (bus.bus_rdata),
    .sel_c        (sel_c),
    .wdata_c      (st_data_c),
    .load_data_c  (ld_data_c),
    .misaligned_c (misaligned_c)
  );

  assign is_mem       = acc_size(aluop_i) != ACC_NONE;
  assign go           = is_mem && !misaligned_c;
  assign timeout_hit  = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
  assign unused_stall = ^{stall[5], stall[3:0]};

  assign bus.bus_req   = req_q;
  assign bus.bus_we    = cmd_q.we;
  assign bus.bus_addr  = cmd_q.addr;
  assign bus.bus_sel   = cmd_q.sel;
  assign bus.bus_wdata = cmd_q.wdata;

  // State register
  always_ff @(posedge clk) begin
    if (clr) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; ack beats a coincident timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (go) state_d = ST_BUSY;
      ST_BUSY: if (bus.bus_ack || timeout_hit) state_d = ST_DONE;
      ST_DONE: if (!stall[4]) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus command, read capture, error flag and timeout counter
  always_ff @(posedge clk) begin
    if (clr) begin
      cmd_q   <= '0;
      req_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (go) begin
          cmd_q <= '{we: is_store(aluop_i), addr: {mem_addr_i[31:2], 2'b00},
                     sel: sel_c, wdata: st_data_c};
          req_q <= 1'b1;
          cnt_q <= '0;
        end
        ST_BUSY: if (bus.bus_ack) begin
          rdata_q <= ld_data_c;
          req_q   <= 1'b0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (timeout_hit) begin
            req_q <= 1'b0;
            err_q <= 1'b1;
          end
        end
        ST_DONE: if (!stall[4]) err_q <= 1'b0;
        default: ;
      endcase
    end
  end

  // Writeback and status outputs
  always_comb begin
    wd_o      = wd_i;
    wreg_o    = wreg_i;
    wdata_o   = wdata_i;
    hi_o      = hi_i;
    lo_o      = lo_i;
    whilo_o   = whilo_i;
    stallreq  = 1'b0;
    align_err = 1'b0;
    bus_err   = 1'b0;
    case (state_q)
      ST_IDLE: if (is_mem) begin
        if (misaligned_c) begin
          align_err = 1'b1;
          wreg_o    = 1'b0;
        end else begin
          stallreq = 1'b1;
        end
      end
      ST_BUSY: stallreq = 1'b1;
      ST_DONE: begin
        if (is_store(aluop_i)) wreg_o  = 1'b0;
        else                   wdata_o = rdata_q;
        if (err_q) begin
          wreg_o  = 1'b0;
          bus_err = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Randomized self-checking bench for mem_bus_ctrl against a behavioural reference model.
module tb_mem_bus_ctrl;
  import mem_bus_ctrl_pkg::*;

  localparam int TMO = 4;

  logic      clk = 1'b0;
  logic      clr;
  logic [5:0] stall;
  reg_addr_t wd_i, wd_o;
  logic      wreg_i, wreg_o, whilo_i, whilo_o;
  reg_t      wdata_i, wdata_o, hi_i, hi_o, lo_i, lo_o, mem_addr_i, reg2_i;
  alu_op_t   aluop_i;
  logic      stallreq, align_err, bus_err;

  int checks = 0;
  int failures = 0;

  mem_bus_ctrl_if bus_if ();

  mem_bus_ctrl #(.TIMEOUT(TMO)) dut (
    .clk(clk), .clr(clr), .stall(stall),
    .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i), .hi_i(hi_i), .lo_i(lo_i),
    .whilo_i(whilo_i), .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i),
    .bus(bus_if),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .hi_o(hi_o), .lo_o(lo_o),
    .whilo_o(whilo_o), .stallreq(stallreq), .align_err(align_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int m_size(input alu_op_t op);
    if (op == EXE_LB_OP || op == EXE_LBU_OP || op == EXE_SB_OP) return 1;
    if (op == EXE_LH_OP || op == EXE_LHU_OP || op == EXE_SH_OP) return 2;
    if (op == EXE_LW_OP || op == EXE_SW_OP) return 4;
    return 0;
  endfunction

  function automatic bit m_is_load(input alu_op_t op);
    return op == EXE_LB_OP || op == EXE_LBU_OP || op == EXE_LH_OP ||
           op == EXE_LHU_OP || op == EXE_LW_OP;
  endfunction

  function automatic bit m_misaligned(input alu_op_t op, input reg_t addr);
    return (addr % m_size(op)) != 0;
  endfunction

  function automatic logic [3:0] m_sel(input alu_op_t op, input reg_t addr);
    int idx = int'(addr % 4);
    if (m_size(op) == 1) return 4'b1000 >> idx;
    if (m_size(op) == 2) return 4'b1100 >> idx;
    return 4'b1111;
  endfunction

  function automatic reg_t m_wdata(input alu_op_t op, input reg_t r2);
    if (m_size(op) == 1) return (r2 & 32'hFF) * 32'h0101_0101;
    if (m_size(op) == 2) return (r2 & 32'hFFFF) * 32'h0001_0001;
    return r2;
  endfunction

  function automatic reg_t m_load(input alu_op_t op, input reg_t addr, input reg_t rd);
    int   idx = int'(addr % 4);
    reg_t v;
    bit   sgn = (op == EXE_LB_OP) || (op == EXE_LH_OP);
    if (m_size(op) == 1) begin
      v = (rd >> (8 * (3 - idx))) & 32'hFF;
      if (sgn && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (m_size(op) == 2) begin
      v = (rd >> (16 - 8 * idx)) & 32'hFFFF;
      if (sgn && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive_nop();
    aluop_i    = EXE_OR_OP;
    mem_addr_i = $urandom;
    reg2_i     = $urandom;
    wd_i       = 5'($urandom);
    wreg_i     = 1'b1;
    wdata_i    = $urandom;
    hi_i       = $urandom;
    lo_i       = $urandom;
    whilo_i    = 1'($urandom);
    stall      = '0;
    bus_if.bus_ack = 1'b0;
  endtask

  // One full memory op from IDLE back to IDLE; ack_at = BUSY cycle index carrying ack (-1: never)
  task automatic run_mem(input alu_op_t op, input reg_t addr, input reg_t r2, input reg_t rd,
                         input int ack_at, input int hold, input string tag);
    bit   mis, ld, st, acked, exp_wreg;
    int   exp_busy, busy;
    reg_t e_load;
    mis      = m_misaligned(op, addr);
    ld       = m_is_load(op);
    st       = !ld;
    acked    = (ack_at >= 0) && (ack_at < TMO);
    exp_busy = acked ? ack_at + 1 : TMO;
    e_load   = m_load(op, addr, rd);

    @(posedge clk); #1;
    drive_nop();
    aluop_i = op; mem_addr_i = addr; reg2_i = r2; bus_if.bus_rdata = rd;
    @(negedge clk);
    checks++;
    if (stallreq !== !mis || align_err !== mis || bus_if.bus_req !== 1'b0) begin
      failures++;
      $display("FAIL %s_issue: stallreq=%b align_err=%b bus_req=%b, want %b %b 0",
               tag, stallreq, align_err, bus_if.bus_req, !mis, mis);
    end
    if (mis) begin
      checks++;
      if (wreg_o !== 1'b0) begin
        failures++; $display("FAIL %s_wreg: wreg_o=%b want 0", tag, wreg_o);
      end
      repeat (3) begin
        @(posedge clk); #1; @(negedge clk);
        checks++;
        if (bus_if.bus_req !== 1'b0 || stallreq !== 1'b0 || align_err !== 1'b1) begin
          failures++;
          $display("FAIL %s_misalign_hold: bus_req=%b stallreq=%b align_err=%b want 0 0 1",
                   tag, bus_if.bus_req, stallreq, align_err);
        end
      end
      @(posedge clk); #1; drive_nop();
      return;
    end

    busy = 0;
    forever begin
      @(posedge clk); #1;
      bus_if.bus_ack = (busy == ack_at);
      @(negedge clk);
      if (stallreq !== 1'b1) break;
      checks++;
      if (bus_if.bus_req !== 1'b1 || bus_if.bus_addr !== (addr & 32'hFFFF_FFFC) ||
          bus_if.bus_sel !== m_sel(op, addr) || bus_if.bus_we !== st ||
          (st && bus_if.bus_wdata !== m_wdata(op, r2))) begin
        failures++;
        $display("FAIL %s_busy%0d: req=%b addr=%h sel=%b we=%b wdata=%h want 1 %h %b %b %h",
                 tag, busy, bus_if.bus_req, bus_if.bus_addr, bus_if.bus_sel, bus_if.bus_we,
                 bus_if.bus_wdata, addr & 32'hFFFF_FFFC, m_sel(op, addr), st, m_wdata(op, r2));
      end
      busy++;
      if (busy > 40) begin
        failures++;
        $display("FAIL %s_stuck: stallreq still high after %0d cycles", tag, busy);
        break;
      end
    end
    bus_if.bus_ack = 1'b0;
    checks++;
    if (busy != exp_busy) begin
      failures++; $display("FAIL %s_latency: busy_cycles=%0d want %0d", tag, busy, exp_busy);
    end

    exp_wreg = ld && acked && wreg_i;
    for (int i = 0; i <= hold; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
        if (i == hold) stall = '0;
        @(negedge clk);
      end else if (hold > 0) begin
        stall = 6'b010000;
      end
      checks++;
      if (bus_if.bus_req !== 1'b0 || stallreq !== 1'b0 || bus_err !== !acked ||
          wreg_o !== exp_wreg || wd_o !== wd_i ||
          (ld && acked && wdata_o !== e_load) || (st && wdata_o !== wdata_i)) begin
        failures++;
        $display("FAIL %s_done%0d: req=%b stallreq=%b bus_err=%b wreg=%b wdata=%h want 0 0 %b %b %h",
                 tag, i, bus_if.bus_req, stallreq, bus_err, wreg_o, wdata_o, !acked, exp_wreg,
                 st ? wdata_i : e_load);
      end
    end

    @(posedge clk); #1;
    drive_nop();
    @(negedge clk);
    checks++;
    if (stallreq !== 1'b0 || bus_err !== 1'b0 || bus_if.bus_req !== 1'b0 || wdata_o !== wdata_i) begin
      failures++;
      $display("FAIL %s_idle: stallreq=%b bus_err=%b req=%b wdata=%h want 0 0 0 %h",
               tag, stallreq, bus_err, bus_if.bus_req, wdata_o, wdata_i);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive_nop();
    bus_if.bus_rdata = '0;
    clr = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus_if.bus_req !== 1'b0 || bus_if.bus_we !== 1'b0 || bus_if.bus_addr !== 32'h0 ||
        bus_if.bus_sel !== 4'h0 || bus_if.bus_wdata !== 32'h0 || stallreq !== 1'b0 || bus_err !== 1'b0) begin
      failures++;
      $display("FAIL reset: req=%b we=%b addr=%h sel=%b wdata=%h stallreq=%b bus_err=%b want all 0",
               bus_if.bus_req, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_sel, bus_if.bus_wdata,
               stallreq, bus_err);
    end
    @(posedge clk); #1; clr = 1'b0;
  endtask

  task automatic test_passthrough(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      drive_nop();
      if (i == 0) begin
        wdata_i = 32'h1234; wd_i = 5'd5;
      end else begin
        aluop_i = 8'($urandom);
        if (m_size(aluop_i) != 0) aluop_i = EXE_OR_OP;
      end
      @(negedge clk);
      checks++;
      if (wd_o !== wd_i || wreg_o !== wreg_i || wdata_o !== wdata_i || hi_o !== hi_i ||
          lo_o !== lo_i || whilo_o !== whilo_i || stallreq !== 1'b0 || bus_if.bus_req !== 1'b0 ||
          align_err !== 1'b0) begin
        failures++;
        $display("FAIL passthrough%0d: wd=%h wdata=%h hi=%h lo=%h stallreq=%b req=%b want %h %h %h %h 0 0",
                 i, wd_o, wdata_o, hi_o, lo_o, stallreq, bus_if.bus_req, wd_i, wdata_i, hi_i, lo_i);
      end
    end
  endtask

  task automatic test_lb();
    run_mem(EXE_LB_OP,  32'h103, 32'h0, 32'h0000_00F0, 0, 0, "lb");
    run_mem(EXE_LBU_OP, 32'h103, 32'h0, 32'h0000_00F0, 0, 0, "lbu");
  endtask

  task automatic test_sh();
    run_mem(EXE_SH_OP, 32'h202, 32'hAAAA_5678, 32'h0, 3, 0, "sh");
  endtask

  task automatic test_misaligned();
    run_mem(EXE_LW_OP, 32'h101, 32'h0, 32'h0, 0, 0, "lw_mis");
  endtask

  task automatic test_timeout();
    run_mem(EXE_LW_OP, 32'h300, 32'h0, 32'hDEAD_BEEF, -1, 0, "timeout");
    @(posedge clk); #1; bus_if.bus_ack = 1'b1;
    @(negedge clk);
    @(posedge clk); #1; bus_if.bus_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_if.bus_req !== 1'b0 || stallreq !== 1'b0 || bus_err !== 1'b0) begin
      failures++;
      $display("FAIL idle_ack: req=%b stallreq=%b bus_err=%b want 0 0 0",
               bus_if.bus_req, stallreq, bus_err);
    end
  endtask

  task automatic test_hold();
    run_mem(EXE_LH_OP, 32'h482, 32'h0, 32'h1234_8001, 1, 3, "hold");
  endtask

  task automatic test_clr_busy();
    @(posedge clk); #1;
    drive_nop();
    aluop_i = EXE_LW_OP; mem_addr_i = 32'h540;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (bus_if.bus_req !== 1'b1) begin
      failures++; $display("FAIL clr_pre: bus_req=%b want 1", bus_if.bus_req);
    end
    @(posedge clk); #1; clr = 1'b1;
    @(posedge clk); #1; clr = 1'b0; bus_if.bus_ack = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_if.bus_req !== 1'b0 || stallreq !== 1'b1 || bus_if.bus_addr !== 32'h0) begin
      failures++;
      $display("FAIL clr_busy: req=%b stallreq=%b addr=%h want 0 1 00000000",
               bus_if.bus_req, stallreq, bus_if.bus_addr);
    end
    @(posedge clk); #1; clr = 1'b1; drive_nop();
    @(posedge clk); #1; clr = 1'b0;
  endtask

  task automatic test_random(input int n);
    alu_op_t ops [8] = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP,
                         EXE_LW_OP, EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
    for (int i = 0; i < n; i++) begin
      run_mem(ops[$urandom_range(0, 7)], $urandom, $urandom, $urandom,
              int'($urandom_range(0, 5)), int'($urandom_range(0, 2)), "rand");
      if ($urandom_range(0, 2) == 0) test_passthrough(1);
    end
  endtask

  initial begin
    clr = 1'b0;
    test_reset();
    test_passthrough(4);
    test_lb();
    test_sh();
    test_misaligned();
    test_timeout();
    test_hold();
    test_clr_busy();
    test_random(40);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
